// File: rtl/mem_rd_arbiter_if.sv
// Read-port bundle between the two cache clients, the arbiter and mem_wrap.
// The slave view is the arbiter; the master view is the environment
// (caches plus memory) that drives requests and returns memory data.
interface mem_rd_arbiter_if #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 32
);
    logic              c0_rreq;
    logic [ADDR_W-1:0] c0_raddr;
    logic [DATA_W-1:0] c0_rdata;
    logic              c0_rvalid;
    logic              c0_busy;

    logic              c1_rreq;
    logic [ADDR_W-1:0] c1_raddr;
    logic [DATA_W-1:0] c1_rdata;
    logic              c1_rvalid;
    logic              c1_busy;

    logic              mem_rreq;
    logic [ADDR_W-1:0] mem_raddr;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_rvalid;

    modport slave (
        input  c0_rreq, c0_raddr, c1_rreq, c1_raddr, mem_rdata, mem_rvalid,
        output c0_rdata, c0_rvalid, c0_busy, c1_rdata, c1_rvalid, c1_busy,
               mem_rreq, mem_raddr
    );

    modport master (
        output c0_rreq, c0_raddr, c1_rreq, c1_raddr, mem_rdata, mem_rvalid,
        input  c0_rdata, c0_rvalid, c0_busy, c1_rdata, c1_rvalid, c1_busy,
               mem_rreq, mem_raddr
    );
endinterface

// File: rtl/mem_rd_arbiter.sv
// Two-client round-robin read arbiter in front of the single mem_wrap read
// port. Each client pulse is latched, one memory read is in flight at a
// time, and the returned word is steered back to the client that asked.
module mem_rd_arbiter #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 32
) (
    input  logic           clk,
    input  logic           reset,
    mem_rd_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t                   state_q, state_d;
    logic [1:0]               pend_q, pend_d;
    logic [1:0][ADDR_W-1:0]   addr_q, addr_d;
    logic                     grant_q, grant_d;
    logic                     last_grant_q, last_grant_d;
    logic                     mem_rreq_q, mem_rreq_d;
    logic [ADDR_W-1:0]        mem_raddr_q, mem_raddr_d;
    logic [1:0][DATA_W-1:0]   rdata_q, rdata_d;
    logic [1:0]               rvalid_q, rvalid_d;

    logic [1:0]               rreq;
    logic [1:0][ADDR_W-1:0]   raddr;
    logic [1:0]               busy;
    logic                     pick;

    assign rreq  = {bus.c1_rreq, bus.c0_rreq};
    assign raddr = {bus.c1_raddr, bus.c0_raddr};

    // A client is busy while its request waits or while it owns the memory port.
    assign busy[0] = pend_q[0] | ((state_q != IDLE) & ~grant_q);
    assign busy[1] = pend_q[1] | ((state_q != IDLE) &  grant_q);

    // Round-robin choice: on a tie the client not served last wins.
    assign pick = (&pend_q) ? ~last_grant_q : pend_q[1];

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            pend_q       <= '0;
            addr_q       <= '0;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            mem_rreq_q   <= 1'b0;
            mem_raddr_q  <= '0;
            rdata_q      <= '0;
            rvalid_q     <= '0;
        end else begin
            state_q      <= state_d;
            pend_q       <= pend_d;
            addr_q       <= addr_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            mem_rreq_q   <= mem_rreq_d;
            mem_raddr_q  <= mem_raddr_d;
            rdata_q      <= rdata_d;
            rvalid_q     <= rvalid_d;
        end
    end

    // Next state: issue when anything is pending, wait for the single return.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (|pend_q) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (bus.mem_rvalid) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request capture, grant/issue and data return.
    always_comb begin
        pend_d       = pend_q;
        addr_d       = addr_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        mem_rreq_d   = 1'b0;
        mem_raddr_d  = mem_raddr_q;
        rdata_d      = rdata_q;
        rvalid_d     = 2'b00;

        // A pulse from a busy client is dropped so its address is not clobbered.
        for (int n = 0; n < 2; n++) begin
            if (rreq[n] && !busy[n]) begin
                pend_d[n] = 1'b1;
                addr_d[n] = raddr[n];
            end
        end

        case (state_q)
            IDLE: begin
                if (|pend_q) begin
                    grant_d      = pick;
                    mem_rreq_d   = 1'b1;
                    mem_raddr_d  = addr_q[pick];
                    pend_d[pick] = 1'b0;
                end
            end
            WAIT: begin
                if (bus.mem_rvalid) begin
                    rdata_d[grant_q]  = bus.mem_rdata;
                    rvalid_d[grant_q] = 1'b1;
                    last_grant_d      = grant_q;
                end
            end
            default: ;
        endcase
    end

    assign bus.mem_rreq  = mem_rreq_q;
    assign bus.mem_raddr = mem_raddr_q;
    assign bus.c0_rdata  = rdata_q[0];
    assign bus.c1_rdata  = rdata_q[1];
    assign bus.c0_rvalid = rvalid_q[0];
    assign bus.c1_rvalid = rvalid_q[1];
    assign bus.c0_busy   = busy[0];
    assign bus.c1_busy   = busy[1];
endmodule

// File: tb/tb_mem_rd_arbiter.sv
// Bench for mem_rd_arbiter: directed scenarios plus a randomized run checked
// against a transaction-level round-robin model and a behavioural memory.
`timescale 1ns/1ps
module tb_mem_rd_arbiter;
    localparam int AW = 13;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mem_rd_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    mem_rd_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (.clk(clk), .reset(reset), .bus(bus));

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_word(input logic [12:0] a);
        if (a == 13'h0001) return 32'hDEADBEEF;
        return (32'h9E3779B9 * {19'd0, a}) + 32'h01234567;
    endfunction

    // Behavioural memory: one response per request after a random latency.
    logic        resp_rv = 1'b0;
    logic        stray_rv = 1'b0;
    logic [31:0] resp_data = 32'h0;
    bit          resp_pend = 1'b0;
    int          resp_cnt = 0;
    logic [12:0] resp_addr = '0;
    int          lat_lo = 0;
    int          lat_hi = 2;
    int          proto_err = 0;
    assign bus.mem_rvalid = resp_rv | stray_rv;
    assign bus.mem_rdata  = resp_data;

    always @(negedge clk) begin
        resp_rv = 1'b0;
        if (!reset) begin
            resp_pend = 1'b0;
        end else begin
            if (resp_pend) begin
                if (bus.mem_raddr !== resp_addr) proto_err++;
                if (resp_cnt == 0) begin
                    resp_rv   = 1'b1;
                    resp_data = mem_word(resp_addr);
                    resp_pend = 1'b0;
                end else begin
                    resp_cnt--;
                end
            end
            if (bus.mem_rreq) begin
                resp_pend = 1'b1;
                resp_addr = bus.mem_raddr;
                resp_cnt  = $urandom_range(lat_hi, lat_lo);
            end
        end
    end

    // Event log of memory issues and client returns.
    logic [12:0] log_ma[$];
    int          log_mc[$];
    logic [31:0] log_r0[$];
    logic [31:0] log_r1[$];
    logic        prev_mreq = 1'b0;
    always @(negedge clk) begin
        if (bus.mem_rreq) begin
            log_ma.push_back(bus.mem_raddr);
            log_mc.push_back(cyc);
            if (prev_mreq) proto_err++;
        end
        if (bus.c0_rvalid) log_r0.push_back(bus.c0_rdata);
        if (bus.c1_rvalid) log_r1.push_back(bus.c1_rdata);
        if (bus.c0_rvalid && bus.c1_rvalid) proto_err++;
        prev_mreq = bus.mem_rreq;
    end

    task automatic clear_logs();
        log_ma.delete(); log_mc.delete(); log_r0.delete(); log_r1.delete();
        proto_err = 0;
    endtask

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic pulse(input logic r0, input logic [12:0] a0, input logic r1, input logic [12:0] a1);
        bus.c0_rreq = r0; bus.c0_raddr = a0;
        bus.c1_rreq = r1; bus.c1_raddr = a1;
        @(posedge clk); #1;
        bus.c0_rreq = 1'b0; bus.c1_rreq = 1'b0;
    endtask

    task automatic do_reset();
        bus.c0_rreq = 1'b0; bus.c1_rreq = 1'b0;
        bus.c0_raddr = '0;  bus.c1_raddr = '0;
        stray_rv = 1'b0;
        reset = 1'b0;
        #30;
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    task automatic drain();
        int k = 0;
        while ((bus.c0_busy || bus.c1_busy || resp_pend) && k < 200) begin
            tick(1); k++;
        end
        tick(2);
        tests++;
        if (k >= 200) begin fails++; $display("FAIL drain: transaction never completed after %0d cycles", k); end
    endtask

    task automatic test_reset();
        bus.c0_rreq = 1'b0; bus.c1_rreq = 1'b0;
        bus.c0_raddr = '0;  bus.c1_raddr = '0;
        #3 reset = 1'b0;
        #30;
        @(negedge clk);
        tests++;
        if ({bus.mem_rreq, bus.mem_raddr} !== '0) begin fails++;
            $display("FAIL reset_mem: got rreq=%b addr=%h expected 0", bus.mem_rreq, bus.mem_raddr); end
        tests++;
        if ({bus.c0_rdata, bus.c0_rvalid, bus.c0_busy} !== '0) begin fails++;
            $display("FAIL reset_c0: got data=%h v=%b busy=%b expected 0", bus.c0_rdata, bus.c0_rvalid, bus.c0_busy); end
        tests++;
        if ({bus.c1_rdata, bus.c1_rvalid, bus.c1_busy} !== '0) begin fails++;
            $display("FAIL reset_c1: got data=%h v=%b busy=%b expected 0", bus.c1_rdata, bus.c1_rvalid, bus.c1_busy); end
        @(posedge clk); #1;
        reset = 1'b1;
        clear_logs();
        tick(10);
        tests++;
        if (log_ma.size() != 0) begin fails++;
            $display("FAIL reset_idle: got %0d mem_rreq expected 0", log_ma.size()); end
    endtask

    task automatic test_single();
        int cap;
        do_reset(); clear_logs();
        cap = cyc + 1;
        pulse(1'b1, 13'h0001, 1'b0, 13'h0000);
        tests++;
        if (bus.c0_busy !== 1'b1) begin fails++;
            $display("FAIL single_busy: got %b expected 1", bus.c0_busy); end
        drain();
        tests++;
        if (log_ma.size() != 1 || log_ma[0] !== 13'h0001) begin fails++;
            $display("FAIL single_addr: got n=%0d addr=%h expected 1 x 0001", log_ma.size(), log_ma.size() ? log_ma[0] : 13'h0); end
        tests++;
        if (log_mc.size() != 1 || log_mc[0] != cap + 1) begin fails++;
            $display("FAIL single_latency: got cycle %0d expected %0d", log_mc.size() ? log_mc[0] : -1, cap + 1); end
        tests++;
        if (log_r0.size() != 1 || log_r0[0] !== 32'hDEADBEEF) begin fails++;
            $display("FAIL single_data: got n=%0d data=%h expected 1 x deadbeef", log_r0.size(), log_r0.size() ? log_r0[0] : 32'h0); end
        tests++;
        if (log_r1.size() != 0) begin fails++;
            $display("FAIL single_c1: got %0d c1 returns expected 0", log_r1.size()); end
        tests++;
        if (bus.c0_rdata !== 32'hDEADBEEF || bus.c0_busy !== 1'b0) begin fails++;
            $display("FAIL single_hold: got data=%h busy=%b expected deadbeef 0", bus.c0_rdata, bus.c0_busy); end
        tests++;
        if (proto_err != 0) begin fails++;
            $display("FAIL single_proto: got %0d protocol errors expected 0", proto_err); end
    endtask

    task automatic test_collision();
        do_reset(); clear_logs();
        pulse(1'b1, 13'h0001, 1'b1, 13'h1012);
        drain();
        tests++;
        if (log_ma.size() != 2 || log_ma[0] !== 13'h0001 || log_ma[1] !== 13'h1012) begin fails++;
            $display("FAIL collision_order: got n=%0d first=%h expected 0001,1012", log_ma.size(), log_ma.size() ? log_ma[0] : 13'h0); end
        tests++;
        if (log_r0.size() != 1 || log_r0[0] !== mem_word(13'h0001)) begin fails++;
            $display("FAIL collision_c0: got n=%0d expected %h", log_r0.size(), mem_word(13'h0001)); end
        tests++;
        if (log_r1.size() != 1 || log_r1[0] !== mem_word(13'h1012)) begin fails++;
            $display("FAIL collision_c1: got n=%0d expected %h", log_r1.size(), mem_word(13'h1012)); end
    endtask

    task automatic test_fairness();
        int n0 = 1, n1 = 1, k = 0;
        logic [12:0] exp_a[6];
        logic r0, r1;
        do_reset(); clear_logs();
        pulse(1'b1, 13'h0100, 1'b1, 13'h1200);
        while ((n0 < 3 || n1 < 3) && k < 300) begin
            r0 = bus.c0_rvalid && n0 < 3;
            r1 = bus.c1_rvalid && n1 < 3;
            if (r0 || r1) begin
                pulse(r0, 13'(13'h0100 + n0), r1, 13'(13'h1200 + n1));
                if (r0) n0++;
                if (r1) n1++;
            end else begin
                tick(1);
            end
            k++;
        end
        drain();
        for (int i = 0; i < 3; i++) begin
            exp_a[2*i]   = 13'(13'h0100 + i);
            exp_a[2*i+1] = 13'(13'h1200 + i);
        end
        tests++;
        if (log_ma.size() != 6) begin fails++;
            $display("FAIL fair_count: got %0d grants expected 6", log_ma.size()); end
        for (int i = 0; i < 6 && i < log_ma.size(); i++) begin
            tests++;
            if (log_ma[i] !== exp_a[i]) begin fails++;
                $display("FAIL fair_grant%0d: got %h expected %h", i, log_ma[i], exp_a[i]); end
        end
    endtask

    task automatic test_ignored();
        do_reset(); clear_logs();
        lat_lo = 4; lat_hi = 4;
        pulse(1'b0, 13'h0, 1'b1, 13'h0123);
        tick(1);
        tests++;
        if (bus.c1_busy !== 1'b1) begin fails++;
            $display("FAIL ignored_busy: got %b expected 1", bus.c1_busy); end
        pulse(1'b0, 13'h0, 1'b1, 13'h0ABC);
        drain();
        lat_lo = 0; lat_hi = 2;
        tests++;
        if (log_ma.size() != 1 || log_ma[0] !== 13'h0123) begin fails++;
            $display("FAIL ignored_addr: got n=%0d first=%h expected 1 x 0123", log_ma.size(), log_ma.size() ? log_ma[0] : 13'h0); end
        tests++;
        if (log_r1.size() != 1 || log_r1[0] !== mem_word(13'h0123)) begin fails++;
            $display("FAIL ignored_data: got n=%0d expected 1 x %h", log_r1.size(), mem_word(13'h0123)); end
        // Memory valid with nothing outstanding must not reach a client.
        clear_logs();
        stray_rv = 1'b1;
        tick(1);
        stray_rv = 1'b0;
        tick(3);
        tests++;
        if (log_r0.size() + log_r1.size() + log_ma.size() != 0) begin fails++;
            $display("FAIL stray_rvalid: got %0d/%0d returns expected none", log_r0.size(), log_r1.size()); end
    endtask

    task automatic test_reset_mid();
        do_reset(); clear_logs();
        lat_lo = 20; lat_hi = 20;
        pulse(1'b1, 13'h0005, 1'b0, 13'h0);
        tick(2);
        pulse(1'b0, 13'h0, 1'b1, 13'h0006);
        tick(2);
        tests++;
        if (bus.c1_busy !== 1'b1) begin fails++;
            $display("FAIL midrst_pending: got c1_busy=%b expected 1", bus.c1_busy); end
        reset = 1'b0;
        #2;
        tests++;
        if ({bus.c0_busy, bus.c1_busy, bus.c0_rvalid, bus.c1_rvalid, bus.mem_rreq} !== 5'b0) begin fails++;
            $display("FAIL midrst_clear: got %b expected 00000",
                {bus.c0_busy, bus.c1_busy, bus.c0_rvalid, bus.c1_rvalid, bus.mem_rreq}); end
        tick(3);
        reset = 1'b1;
        lat_lo = 0; lat_hi = 2;
        tick(30);
        tests++;
        if (log_r0.size() + log_r1.size() != 0 || log_ma.size() != 1) begin fails++;
            $display("FAIL midrst_quiet: got r0=%0d r1=%0d mreq=%0d expected 0 0 1", log_r0.size(), log_r1.size(), log_ma.size()); end
        clear_logs();
        pulse(1'b0, 13'h0, 1'b1, 13'h0777);
        drain();
        tests++;
        if (log_ma.size() != 1 || log_ma[0] !== 13'h0777 || log_r1.size() != 1 || log_r1[0] !== mem_word(13'h0777)) begin fails++;
            $display("FAIL midrst_after: got mreq=%0d r1=%0d expected one read of 0777", log_ma.size(), log_r1.size()); end
        tests++;
        if (log_r0.size() != 0) begin fails++;
            $display("FAIL midrst_c0: got %0d c0 returns expected 0", log_r0.size()); end
    endtask

    typedef struct {
        logic [12:0] a;
        int          cap;
    } req_t;

    task automatic test_random();
        req_t rq0[$], rq1[$];
        logic [31:0] e0[$], e1[$];
        logic mb0 = 1'b0, mb1 = 1'b0, r0, r1;
        logic [12:0] a0, a1, ea;
        int lg = 1, g, m, bad;
        bit el0, el1;
        do_reset(); clear_logs();
        lat_lo = 0; lat_hi = 3;
        for (int t = 0; t < 400; t++) begin
            if (bus.c0_rvalid) mb0 = 1'b0;
            if (bus.c1_rvalid) mb1 = 1'b0;
            r0 = 1'b0; r1 = 1'b0;
            a0 = 13'($urandom); a1 = 13'($urandom);
            if (!mb0 && $urandom_range(3, 0) == 0) begin
                r0 = 1'b1; mb0 = 1'b1; rq0.push_back('{a0, cyc + 1});
            end else if (mb0 && $urandom_range(7, 0) == 0) begin
                r0 = 1'b1;
            end
            if (!mb1 && $urandom_range(3, 0) == 0) begin
                r1 = 1'b1; mb1 = 1'b1; rq1.push_back('{a1, cyc + 1});
            end else if (mb1 && $urandom_range(7, 0) == 0) begin
                r1 = 1'b1;
            end
            pulse(r0, a0, r1, a1);
        end
        drain();
        // Replay the issue log through the round-robin rules.
        bad = 0;
        for (int i = 0; i < log_ma.size(); i++) begin
            m   = log_mc[i];
            el0 = rq0.size() > 0 && rq0[0].cap < m;
            el1 = rq1.size() > 0 && rq1[0].cap < m;
            g   = (el0 && el1) ? 1 - lg : el0 ? 0 : el1 ? 1 : -1;
            if (g < 0) begin
                bad++;
            end else begin
                ea = (g == 1) ? rq1[0].a : rq0[0].a;
                if (log_ma[i] !== ea) bad++;
                if (g == 1) begin e1.push_back(mem_word(ea)); void'(rq1.pop_front()); end
                else        begin e0.push_back(mem_word(ea)); void'(rq0.pop_front()); end
                lg = g;
            end
        end
        tests++;
        if (bad != 0) begin fails++;
            $display("FAIL rand_grants: got %0d wrong grants out of %0d expected 0", bad, log_ma.size()); end
        tests++;
        if (rq0.size() + rq1.size() != 0) begin fails++;
            $display("FAIL rand_unserved: got %0d requests never issued expected 0", rq0.size() + rq1.size()); end
        tests++;
        if (log_r0.size() != e0.size() || log_r1.size() != e1.size()) begin fails++;
            $display("FAIL rand_count: got %0d/%0d returns expected %0d/%0d", log_r0.size(), log_r1.size(), e0.size(), e1.size()); end
        bad = 0;
        for (int i = 0; i < e0.size() && i < log_r0.size(); i++) if (log_r0[i] !== e0[i]) bad++;
        for (int i = 0; i < e1.size() && i < log_r1.size(); i++) if (log_r1[i] !== e1[i]) bad++;
        tests++;
        if (bad != 0) begin fails++;
            $display("FAIL rand_data: got %0d wrong words expected 0", bad); end
        tests++;
        if (proto_err != 0) begin fails++;
            $display("FAIL rand_proto: got %0d protocol errors expected 0", proto_err); end
        tests++;
        if (log_ma.size() < 20) begin fails++;
            $display("FAIL rand_activity: got %0d transactions expected at least 20", log_ma.size()); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_collision();
        test_fairness();
        test_ignored();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
